multiplier_pipe: RTL and testbench

Parametrised, pipelined, multi-lane signed fixed-point multiplier. It is the successor to the single-lane, single-register multiplier used in the PE datapath.
- Adds a valid/ready handshake with backpressure and configurable pipeline depth.
- Adds a per-transaction Q-format shift with round-half-up, plus saturation to the product width with a per-lane flag.
- Sits between the PE scratchpads and the accumulator.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_round_sat.sv | 48 ++++
 rtl/multiplier_pipe.sv | 153 +++++++++++++++
 tb/tb_multiplier_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared width and bound helpers for the pipelined multi-lane multiplier.
package mult_pkg;

  function automatic int full_w(input int w1, input int w2);
    return w1 + w2;
  endfunction

  // Bounds are returned in 64 bits so one signed compare covers any width up to 64.
  function automatic logic signed [63:0] max_val(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_val(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Single-lane round-half-up arithmetic right shift followed by saturation to PROD_W.
module mult_round_sat
  import mult_pkg::*;
#(
  parameter int FULL_W = 16,
  parameter int PROD_W = 20,
  parameter int Q_W    = 5
) (
  input  logic [FULL_W-1:0] prod_full,
  input  logic [Q_W-1:0]    frac_bits,
  output logic [PROD_W-1:0] prod_out,
  output logic              sat
);

  localparam logic signed [63:0] MAX_V = max_val(PROD_W);
  localparam logic signed [63:0] MIN_V = min_val(PROD_W);
  localparam logic [FULL_W:0]    ONE   = {{FULL_W{1'b0}}, 1'b1};

  int                 q_eff;
  logic signed [FULL_W:0] ext;
  logic signed [FULL_W:0] bias;
  logic signed [FULL_W:0] sum;
  logic signed [FULL_W:0] shifted;
  logic signed [63:0]     wide;

  // One guard bit above the product keeps the half-LSB bias from overflowing.
  always_comb begin
    q_eff    = (int'(frac_bits) > FULL_W) ? FULL_W : int'(frac_bits);
    ext      = {prod_full[FULL_W-1], prod_full};
    bias     = '0;
    if (q_eff != 0) begin
      bias = ONE << (q_eff - 1);
    end
    sum      = ext + bias;
    shifted  = sum >>> q_eff;
    wide     = 64'(shifted);
    sat      = 1'b0;
    prod_out = wide[PROD_W-1:0];
    if (wide > MAX_V) begin
      prod_out = MAX_V[PROD_W-1:0];
      sat      = 1'b1;
    end else if (wide < MIN_V) begin
      prod_out = MIN_V[PROD_W-1:0];
      sat      = 1'b1;
    end
  end

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier with valid/ready flow control,
// Q-format round/shift and per-lane saturation in the final stage.
module multiplier_pipe
  import mult_pkg::*;
#(
  parameter int LANES           = 1,
  parameter int DATA_WIDTH_FAC1 = 8,
  parameter int DATA_WIDTH_FAC2 = 8,
  parameter int DATA_WIDTH_PROD = 20,
  parameter int Q_BITWIDTH      = $clog2(DATA_WIDTH_PROD),
  parameter int PIPE_STAGES     = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [LANES*DATA_WIDTH_FAC1-1:0]   factor_1,
  input  logic [LANES*DATA_WIDTH_FAC2-1:0]   factor_2,
  input  logic [Q_BITWIDTH-1:0]              fraction_bit_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [LANES*DATA_WIDTH_PROD-1:0]   product,
  output logic [LANES-1:0]                   sat_o
);

  localparam int FULL_W = full_w(DATA_WIDTH_FAC1, DATA_WIDTH_FAC2);
  localparam int RETIME = PIPE_STAGES - 2;

  logic advance;
  logic accept;

  logic [LANES*DATA_WIDTH_FAC1-1:0] f1_reg;
  logic [LANES*DATA_WIDTH_FAC2-1:0] f2_reg;
  logic [Q_BITWIDTH-1:0]            q1_reg;
  logic                             v1_reg;

  logic [LANES*FULL_W-1:0]          prod_s1;
  logic [LANES*FULL_W-1:0]          final_prod;
  logic [Q_BITWIDTH-1:0]            final_q;
  logic                             final_v;
  logic [LANES*DATA_WIDTH_PROD-1:0] rs_prod;
  logic [LANES-1:0]                 rs_sat;

  // Every stage moves in lockstep; a stalled output freezes the whole pipe.
  assign advance = ready_i | ~valid_o;
  assign ready_o = advance & ~flush_i;
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f1_reg <= '0;
      f2_reg <= '0;
      q1_reg <= '0;
      v1_reg <= 1'b0;
    end else if (flush_i) begin
      f1_reg <= '0;
      f2_reg <= '0;
      q1_reg <= '0;
      v1_reg <= 1'b0;
    end else if (advance) begin
      v1_reg <= accept;
      f1_reg <= accept ? factor_1 : '0;
      f2_reg <= accept ? factor_2 : '0;
      q1_reg <= accept ? fraction_bit_i : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LSB1 = lane_lsb(gi, DATA_WIDTH_FAC1);
      localparam int LSB2 = lane_lsb(gi, DATA_WIDTH_FAC2);
      localparam int LSBF = lane_lsb(gi, FULL_W);
      localparam int LSBP = lane_lsb(gi, DATA_WIDTH_PROD);

      logic signed [FULL_W-1:0] a_ext;
      logic signed [FULL_W-1:0] b_ext;

      // Sign-extending both operands to FULL_W makes the truncated product exact.
      assign a_ext = FULL_W'($signed(f1_reg[LSB1 +: DATA_WIDTH_FAC1]));
      assign b_ext = FULL_W'($signed(f2_reg[LSB2 +: DATA_WIDTH_FAC2]));
      assign prod_s1[LSBF +: FULL_W] = a_ext * b_ext;

      mult_round_sat #(
        .FULL_W (FULL_W),
        .PROD_W (DATA_WIDTH_PROD),
        .Q_W    (Q_BITWIDTH)
      ) u_round_sat (
        .prod_full (final_prod[LSBF +: FULL_W]),
        .frac_bits (final_q),
        .prod_out  (rs_prod[LSBP +: DATA_WIDTH_PROD]),
        .sat       (rs_sat[gi])
      );
    end

    if (RETIME == 0) begin : g_no_retime
      assign final_prod = prod_s1;
      assign final_q    = q1_reg;
      assign final_v    = v1_reg;
    end else begin : g_retime
      logic [LANES*FULL_W-1:0] prod_pipe [RETIME];
      logic [Q_BITWIDTH-1:0]   q_pipe    [RETIME];
      logic                    v_pipe    [RETIME];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < RETIME; i++) begin
            prod_pipe[i] <= '0;
            q_pipe[i]    <= '0;
            v_pipe[i]    <= 1'b0;
          end
        end else if (flush_i) begin
          for (int i = 0; i < RETIME; i++) begin
            prod_pipe[i] <= '0;
            q_pipe[i]    <= '0;
            v_pipe[i]    <= 1'b0;
          end
        end else if (advance) begin
          prod_pipe[0] <= prod_s1;
          q_pipe[0]    <= q1_reg;
          v_pipe[0]    <= v1_reg;
          for (int i = 1; i < RETIME; i++) begin
            prod_pipe[i] <= prod_pipe[i-1];
            q_pipe[i]    <= q_pipe[i-1];
            v_pipe[i]    <= v_pipe[i-1];
          end
        end
      end

      assign final_prod = prod_pipe[RETIME-1];
      assign final_q    = q_pipe[RETIME-1];
      assign final_v    = v_pipe[RETIME-1];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      product <= '0;
      sat_o   <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      product <= '0;
      sat_o   <= '0;
    end else if (advance) begin
      valid_o <= final_v;
      product <= final_v ? rs_prod : '0;
      sat_o   <= final_v ? rs_sat : '0;
    end
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Bench for multiplier_pipe: two configurations driven in parallel, a constant vector
// table, hand-written flow-control sequences and a queue scoreboard on random traffic.
module tb_multiplier_pipe;

  localparam int P_A  = 2;
  localparam int P_B  = 3;
  localparam int PW_A = 20;
  localparam int PW_B = 12;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, valid_i, ready_i;
  logic [15:0] factor_1, factor_2;
  logic [4:0]  fraction_bit;
  logic        ready_o_a, valid_o_a, ready_o_b, valid_o_b;
  logic [39:0] product_a;
  logic [23:0] product_b;
  logic [1:0]  sat_a, sat_b;

  always #5 clk = ~clk;

  multiplier_pipe #(.LANES(2), .PIPE_STAGES(P_A)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o_a),
    .factor_1(factor_1), .factor_2(factor_2), .fraction_bit_i(fraction_bit),
    .valid_o(valid_o_a), .ready_i(ready_i), .product(product_a), .sat_o(sat_a));

  multiplier_pipe #(.LANES(2), .DATA_WIDTH_PROD(PW_B), .Q_BITWIDTH(5), .PIPE_STAGES(P_B)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o_b),
    .factor_1(factor_1), .factor_2(factor_2), .fraction_bit_i(fraction_bit),
    .valid_o(valid_o_b), .ready_i(ready_i), .product(product_b), .sat_o(sat_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Exact reference: floor((p + d/2) / d), d = 2^min(q,16), then clamp to pw bits.
  function automatic void model(input int a, input int b, input int q, input int pw,
                                output longint r, output bit s);
    longint p, num, d, mx, mn;
    int qe;
    p  = longint'(a) * longint'(b);
    qe = (q > 16) ? 16 : q;
    d  = 1;
    repeat (qe) d = d * 2;
    num = p + d / 2;
    r   = num / d;
    if ((num % d) != 0 && num < 0) r = r - 1;
    mx = 1;
    repeat (pw - 1) mx = mx * 2;
    mn = -mx;
    mx = mx - 1;
    s  = 1'b0;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
  endfunction

  typedef struct { longint e0; longint e1; logic [1:0] s; int acc; bit lat; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  function automatic exp_t predict(input int pw);
    exp_t e;
    bit s0, s1;
    model(int'($signed(factor_1[7:0])), int'($signed(factor_2[7:0])), int'(fraction_bit), pw, e.e0, s0);
    model(int'($signed(factor_1[15:8])), int'($signed(factor_2[15:8])), int'(fraction_bit), pw, e.e1, s1);
    e.s   = {s1, s0};
    e.acc = cyc;
    e.lat = lat_en;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) q_a.delete();
    else begin
      if (valid_o_a && ready_i) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_a_extra: got valid output %0h, expected no pending item", product_a);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          chk("sb_a_lane0", $signed(product_a[19:0]), e.e0);
          chk("sb_a_lane1", $signed(product_a[39:20]), e.e1);
          chk("sb_a_sat", sat_a, e.s);
          if (e.lat) chk("sb_a_latency", cyc - e.acc, P_A);
        end
      end
      if (flush_i) q_a.delete();
      else if (valid_i && ready_o_a) q_a.push_back(predict(PW_A));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q_b.delete();
    else begin
      if (valid_o_b && ready_i) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_b_extra: got valid output %0h, expected no pending item", product_b);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          chk("sb_b_lane0", $signed(product_b[11:0]), e.e0);
          chk("sb_b_lane1", $signed(product_b[23:12]), e.e1);
          chk("sb_b_sat", sat_b, e.s);
          if (e.lat) chk("sb_b_latency", cyc - e.acc, P_B);
        end
      end
      if (flush_i) q_b.delete();
      else if (valid_i && ready_o_b) q_b.push_back(predict(PW_B));
    end
  end

  typedef struct {
    int a0; int b0; int a1; int b1; int q;
    longint ea0; longint ea1; int sa;
    longint eb0; longint eb1; int sb;
  } vec_t;
  vec_t vecs[10];

  task automatic send_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    valid_i      = 1'b1;
    factor_1     = {8'(v.a1), 8'(v.a0)};
    factor_2     = {8'(v.b1), 8'(v.b0)};
    fraction_bit = 5'(v.q);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_a_not_early", idx), valid_o_a, 0);
    @(negedge clk);
    chk($sformatf("vec%0d_a_valid", idx), valid_o_a, 1);
    chk($sformatf("vec%0d_a_lane0", idx), $signed(product_a[19:0]), v.ea0);
    chk($sformatf("vec%0d_a_lane1", idx), $signed(product_a[39:20]), v.ea1);
    chk($sformatf("vec%0d_a_sat", idx), sat_a, v.sa);
    @(negedge clk);
    chk($sformatf("vec%0d_b_valid", idx), valid_o_b, 1);
    chk($sformatf("vec%0d_b_lane0", idx), $signed(product_b[11:0]), v.eb0);
    chk($sformatf("vec%0d_b_lane1", idx), $signed(product_b[23:12]), v.eb1);
    chk($sformatf("vec%0d_b_sat", idx), sat_b, v.sb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int i_sent, n_out, k;
    longint bp_e0[5], bp_e1[5];

    vecs[0] = '{10, 10, -11, 10, 0, 100, -110, 0, 100, -110, 0};
    vecs[1] = '{-10, -11, 11, -11, 0, 110, -121, 0, 110, -121, 0};
    vecs[2] = '{10, 11, -10, 11, 3, 14, -14, 0, 14, -14, 0};
    vecs[3] = '{3, 4, 0, 0, 3, 2, 0, 0, 2, 0, 0};
    vecs[4] = '{-128, 127, 127, 127, 16, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{127, 127, -128, 127, 0, 16129, -16256, 0, 2047, -2048, 3};
    vecs[6] = '{10, 10, -128, -128, 0, 100, 16384, 0, 100, 2047, 2};
    vecs[7] = '{-1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0};
    vecs[8] = '{-128, -128, 127, -128, 15, 1, 0, 0, 1, 0, 0};
    vecs[9] = '{127, 127, -128, -128, 20, 0, 0, 0, 0, 0, 0};

    // Reset with a live-looking input: nothing may be captured.
    rst_n = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; fraction_bit = '0;
    factor_1 = {8'd10, 8'd10}; factor_2 = {8'd10, 8'd10};
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_a", valid_o_a, 0);
    chk("reset_product_a", product_a, 0);
    chk("reset_sat_a", sat_a, 0);
    chk("reset_valid_b", valid_o_b, 0);
    chk("reset_product_b", product_b, 0);
    chk("reset_sat_b", sat_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready_a", ready_o_a, 1);
    chk("post_reset_ready_b", ready_o_b, 1);

    lat_en = 1'b1;
    for (int i = 0; i < 10; i++) send_vec(i, vecs[i]);

    // Backpressure: 5 items, ready_i low for 4 cycles mid-stream.
    lat_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bp_e0[j] = 3 * (j + 1);
      bp_e1[j] = -5 * (j + 2);
    end
    i_sent = 0; n_out = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      ready_i = !(t >= 4 && t < 8);
      if (i_sent < 5) begin
        valid_i      = 1'b1;
        factor_1     = {8'(-(i_sent + 2)), 8'(i_sent + 1)};
        factor_2     = {8'd5, 8'd3};
        fraction_bit = '0;
      end else valid_i = 1'b0;
      @(negedge clk);
      if (!ready_i && n_out < 5) begin
        chk("bp_valid_held", valid_o_b, 1);
        chk("bp_ready_low", ready_o_b, 0);
        chk("bp_hold_lane0", $signed(product_b[11:0]), bp_e0[n_out]);
        chk("bp_hold_lane1", $signed(product_b[23:12]), bp_e1[n_out]);
      end
      if (valid_o_b && ready_i) begin
        if (n_out < 5) begin
          chk("bp_order_lane0", $signed(product_b[11:0]), bp_e0[n_out]);
          chk("bp_order_lane1", $signed(product_b[23:12]), bp_e1[n_out]);
        end
        n_out++;
      end
      if (valid_i && ready_o_b) i_sent++;
    end
    chk("bp_count", n_out, 5);

    // Flush with two items in flight.
    @(posedge clk); #1;
    ready_i = 1'b1; valid_i = 1'b1;
    factor_1 = {8'd7, 8'd7}; factor_2 = {8'd7, 8'd7}; fraction_bit = '0;
    @(posedge clk); #1;
    factor_1 = {8'd8, 8'd8};
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready_low_b", ready_o_b, 0);
    chk("flush_ready_low_a", ready_o_a, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("flush_no_output_b", valid_o_b, 0);
      chk("flush_no_output_a", valid_o_a, 0);
    end

    // Asynchronous reset with two items in flight.
    lat_en = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b1; factor_1 = {8'd1, 8'd1}; factor_2 = {8'd2, 8'd2};
    @(posedge clk); #1;
    factor_1 = {8'd3, 8'd3};
    @(posedge clk); #1;
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid_a", valid_o_a, 0);
    chk("midreset_product_a", product_a, 0);
    chk("midreset_valid_b", valid_o_b, 0);
    chk("midreset_product_b", product_b, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; valid_i = 1'b1;
    factor_1 = {8'd4, 8'd4}; factor_2 = {8'd5, 8'd5}; fraction_bit = '0;
    #1 chk("release_ready_b", ready_o_b, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_o_b && k < 10);
    chk("release_latency_b", k, P_B);
    chk("release_lane0_b", $signed(product_b[11:0]), 20);
    chk("release_lane1_b", $signed(product_b[23:12]), 20);

    // Random traffic against the scoreboards.
    lat_en = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      valid_i      = ($urandom_range(0, 3) != 0);
      factor_1     = 16'($urandom);
      factor_2     = 16'($urandom);
      fraction_bit = 5'($urandom_range(0, 18));
      ready_i      = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain_a_empty", q_a.size(), 0);
    chk("drain_b_empty", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
